// File: rtl/argmax_pkg.sv
// Shared types and default widths for the streaming signed max/argmax reducer.
package argmax_pkg;

  localparam int ARGMAX_WIDTH     = 32;
  localparam int ARGMAX_IDX_WIDTH = 16;

  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_ACCUM = 2'd1,
    ST_DONE  = 2'd2
  } state_e;

endpackage

// File: rtl/stream_argmax_int32_if.sv
// Input beat stream and result stream of the argmax reducer, bundled in one interface.
interface stream_argmax_int32_if
  import argmax_pkg::*;
#(
  parameter int WIDTH     = ARGMAX_WIDTH,
  parameter int IDX_WIDTH = ARGMAX_IDX_WIDTH
) ();

  logic                 in_valid;
  logic                 in_ready;
  logic [WIDTH-1:0]     in_data;
  logic                 in_last;
  logic                 out_valid;
  logic                 out_ready;
  logic [WIDTH-1:0]     out_max;
  logic [IDX_WIDTH-1:0] out_idx;
  logic                 out_ovf;

  modport master (
    output in_valid, in_data, in_last, out_ready,
    input  in_ready, out_valid, out_max, out_idx, out_ovf
  );

  modport slave (
    input  in_valid, in_data, in_last, out_ready,
    output in_ready, out_valid, out_max, out_idx, out_ovf
  );

endinterface

// File: rtl/gt_int_nbit.sv
// Strict two's-complement greater-than: Y = (A >s B).
module gt_int_nbit #(
  parameter int WIDTH     = 32,
  parameter int IMPL_TYPE = 0
) (
  input  logic [WIDTH-1:0] A,
  input  logic [WIDTH-1:0] B,
  output logic             Y
);

  generate
    if (IMPL_TYPE == 0) begin : g_signed
      assign Y = $signed(A) > $signed(B);
    end else begin : g_biased
      // Inverting the sign bit maps two's-complement order onto unsigned order.
      assign Y = {~A[WIDTH-1], A[WIDTH-2:0]} > {~B[WIDTH-1], B[WIDTH-2:0]};
    end
  endgenerate

endmodule

// File: rtl/stream_argmax_int32.sv
// Per-frame signed maximum and first-occurrence index of a valid/ready beat stream.
module stream_argmax_int32
  import argmax_pkg::*;
#(
  parameter int WIDTH     = ARGMAX_WIDTH,
  parameter int IDX_WIDTH = ARGMAX_IDX_WIDTH,
  parameter int IMPL_TYPE = 0
) (
  input  logic                 clk,
  input  logic                 rst,
  stream_argmax_int32_if.slave bus
);

  state_e               state_q, state_d;
  logic [WIDTH-1:0]     max_q, max_d;
  logic [IDX_WIDTH-1:0] idx_q, idx_d;
  logic [IDX_WIDTH:0]   cnt_q, cnt_d;
  logic                 ovf_q, ovf_d;
  logic                 gt;
  logic                 beat_fire;
  logic                 past_range;

  gt_int_nbit #(
    .WIDTH    (WIDTH),
    .IMPL_TYPE(IMPL_TYPE)
  ) u_gt (
    .A(bus.in_data),
    .B(max_q),
    .Y(gt)
  );

  assign bus.in_ready  = (state_q != ST_DONE) && !rst;
  assign bus.out_valid = (state_q == ST_DONE);
  assign bus.out_max   = max_q;
  assign bus.out_idx   = idx_q;
  assign bus.out_ovf   = ovf_q;

  assign beat_fire  = bus.in_valid && bus.in_ready;
  // The counter MSB marks beats whose index no longer fits in IDX_WIDTH bits.
  assign past_range = cnt_q[IDX_WIDTH];

  always_comb begin
    state_d = state_q;
    max_d   = max_q;
    idx_d   = idx_q;
    cnt_d   = cnt_q;
    ovf_d   = ovf_q;
    case (state_q)
      ST_IDLE: begin
        if (beat_fire) begin
          max_d   = bus.in_data;
          idx_d   = '0;
          cnt_d   = {{IDX_WIDTH{1'b0}}, 1'b1};
          ovf_d   = 1'b0;
          state_d = bus.in_last ? ST_DONE : ST_ACCUM;
        end
      end
      ST_ACCUM: begin
        if (beat_fire) begin
          if (past_range) begin
            ovf_d = 1'b1;
          end
          if (gt) begin
            max_d = bus.in_data;
            idx_d = past_range ? {IDX_WIDTH{1'b1}} : cnt_q[IDX_WIDTH-1:0];
          end
          if (!past_range) begin
            cnt_d = cnt_q + {{IDX_WIDTH{1'b0}}, 1'b1};
          end
          if (bus.in_last) begin
            state_d = ST_DONE;
          end
        end
      end
      ST_DONE: begin
        if (bus.out_ready) begin
          state_d = ST_IDLE;
        end
      end
      default: state_d = ST_IDLE;
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q <= ST_IDLE;
      max_q   <= '0;
      idx_q   <= '0;
      cnt_q   <= '0;
      ovf_q   <= 1'b0;
    end else begin
      state_q <= state_d;
      max_q   <= max_d;
      idx_q   <= idx_d;
      cnt_q   <= cnt_d;
      ovf_q   <= ovf_d;
    end
  end

endmodule

// File: doc/stream_argmax_int32.md
# stream_argmax_int32

Streaming signed-max/argmax reducer that consumes a valid/ready stream of 32-bit signed integers, framed by a `last` flag, and reports the largest value and its position in each frame. It sits directly downstream of the signed greater-than comparator: each accepted beat is compared against the running maximum with one `gt_int_nbit` instance, and the comparator's `Y` drives the max/index update. Results leave on a valid/ready output port, one result per frame.

## Interface
- `WIDTH`, 32: data width, two's-complement signed.
- `IDX_WIDTH`, 16: width of the beat index and position counter.
- `IMPL_TYPE`, 0: passed unchanged to the `gt_int_nbit` comparator.

- `clk`  in  1  single clock; all state updates on the rising edge.
- `rst`  in  1  asynchronous, active-high reset.
- `in_valid`  in  1  input beat valid.
- `in_ready`  out  1  input beat accepted when `in_valid && in_ready`.
- `in_data`  in  WIDTH  signed input value.
- `in_last`  in  1  marks the final beat of a frame.
- `out_valid`  out  1  result valid.
- `out_ready`  in  1  result consumed when `out_valid && out_ready`.
- `out_max`  out  WIDTH  maximum value of the frame.
- `out_idx`  out  IDX_WIDTH  zero-based index of the first occurrence of the maximum.
- `out_ovf`  out  1  frame exceeded 2^IDX_WIDTH beats; `out_idx` may be saturated.

## Operation
- States: IDLE (no beat of the current frame accepted yet), ACCUM (at least one beat accepted, `in_last` not yet seen), DONE (result held on output).
- IDLE, beat accepted: `max_q` takes `in_data`, `idx_q` takes 0, `cnt_q` takes 1, `ovf_q` takes 0.
  - If `in_last` is set, go to DONE; otherwise go to ACCUM.
- ACCUM, beat accepted: the comparator computes `gt = (in_data >s max_q)` with strict signed compare.
  - If `gt`, `max_q` takes `in_data` and `idx_q` takes `cnt_q`.
  - `cnt_q` increments.
  - If `in_last` is set, go to DONE.
- Ties keep the earlier index, because the compare is strict.
- Signed order: 0x80000000 is the most negative value and 0x7FFFFFFF the most positive.
- DONE: `out_valid`=1, and `out_max`/`out_idx`/`out_ovf` are driven from `max_q`/`idx_q`/`ovf_q`.
  - These outputs hold stable until `out_ready`.
  - On handshake, go to IDLE.
- Counter saturation: `cnt_q` is IDX_WIDTH+1 bits.
  - Once a beat would be assigned an index above 2^IDX_WIDTH−1, `ovf_q` sets.
  - A new maximum found past that point records `idx_q` = all-ones.
  - `cnt_q` saturates and never wraps.
- `in_ready` = 1 in IDLE and ACCUM, 0 in DONE and while `rst` is high. No beat is accepted while a result is pending.
- Gaps (`in_valid`=0) in IDLE or ACCUM leave all state unchanged.

## Timing
- Reset values: state IDLE, `out_valid`=0, `out_max`=0, `out_idx`=0, `out_ovf`=0, internal counters 0.
  - Reset mid-frame or mid-DONE discards the frame and any pending result.
- Latency: `out_valid` rises the cycle after the `in_last` beat is accepted. The result is registered, with no combinational path from `in_data` to the outputs.
- Result handshake at edge N: state is IDLE at N+1, so `in_ready`=1 from cycle N+1. There is no same-cycle bypass.
- Throughput: one beat per cycle inside a frame. Per-frame overhead is one DONE cycle minimum plus any `out_ready` stall.
- A single-beat frame (`in_last` on the first beat) produces that value with index 0, one cycle later.
- `in_ready` depends only on state and `rst`, never on `in_valid`. `out_valid` depends only on state.

## Structure
- Package `argmax_pkg`: state enum (IDLE, ACCUM, DONE) and localparam defaults for WIDTH and IDX_WIDTH.
- One sub-module: `gt_int_nbit` (WIDTH, IMPL_TYPE), with `A`=`in_data`, `B`=`max_q`, `Y`=`gt`. No other comparison logic is written inline.
- Top level holds the FSM, the max/idx/cnt/ovf registers and the handshake logic.

## Test plan
- Frame [3, −5, 7, 7, 2] with `out_ready`=1 → `out_max`=7, `out_idx`=2, `out_ovf`=0; `out_valid` high for exactly one cycle, the cycle after beat 4.
- Frame [0x80000000, 0xFFFFFFFF, 0x7FFFFFFF, 0] → `out_max`=0x7FFFFFFF, `out_idx`=2, confirming signed (not unsigned) ordering.
- Single-beat frame [−1] followed by frame [4, 9]; hold `out_ready`=0 for 5 cycles on the first result.
  - Required: `out_max`=−1 and `out_idx`=0 stay stable, and `in_ready`=0 throughout the stall.
  - Then the second result is `out_max`=9, `out_idx`=1.
- Assert `rst` asynchronously mid-frame after beats [100, 200].
  - Required: all outputs are 0 immediately.
  - A new frame [1] then yields `out_max`=1, `out_idx`=0.
- With IDX_WIDTH=2, frame [1, 2, 3, 4, 9] → `out_max`=9, `out_idx`=3 (saturated), `out_ovf`=1.
- Random valid/ready back-pressure on both ports over 1000 frames, checked against a reference model → results match and no beat is lost or duplicated.
